// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type, address/twiddle widths and N decoding
// for the FFT read-address generator.
package fft_pkg;

  localparam int ADDR_W = 10;
  localparam int TW_W   = 9;
  localparam int SH_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  // N = 8 << code, wide enough for N = 1024
  function automatic logic [ADDR_W:0] fft_n(
    input logic [2:0] code
  );
    return (ADDR_W+1)'(8) << code;
  endfunction

endpackage

// File: rtl/bf_addr_calc.sv
// bf_addr_calc: combinational butterfly addressing for one lane.
// Ports: b/stride/sh in; top/bot operand addresses and twiddle index out.
module bf_addr_calc
  import fft_pkg::*;
(
  input  logic [ADDR_W-1:0] b,
  input  logic [ADDR_W-1:0] stride,
  input  logic [SH_W-1:0]   sh,
  output logic [ADDR_W-1:0] top,
  output logic [ADDR_W-1:0] bot,
  output logic [TW_W-1:0]   twiddle
);

  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] hi;

  // stride is a power of two: j = b mod S, hi = (b / S) * S
  assign mask = stride - ADDR_W'(1);
  assign j    = b & mask;
  assign hi   = b & ~mask;

  // top = g*2S + j ; bot = top + S (bit S is clear in top)
  assign top     = (hi << 1) | j;
  assign bot     = top | stride;
  assign twiddle = TW_W'(j << sh);

endmodule

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: per-stage butterfly read-address/twiddle issue with a
// PIPE-deep output pipeline; LANES butterflies per cycle, ping-pong bank tag.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PIPE  = 2
) (
  input  logic                    clk,
  input  logic                    i_resetn,
  input  logic [2:0]              i_point_configuration,
  input  logic                    i_working,
  input  logic [ADDR_W-1:0]       i_stride,
  input  logic                    i_new_stage_trigger,
  input  logic                    i_sram_read_register,
  input  logic                    i_fft_done,
  output logic [LANES*ADDR_W-1:0] o_addr_top,
  output logic [LANES*ADDR_W-1:0] o_addr_bot,
  output logic [LANES*TW_W-1:0]   o_twiddle_idx,
  output logic                    o_bank_sel,
  output logic                    o_valid,
  output logic                    o_stage_issued
);

  localparam int LW = LANES * ADDR_W;
  localparam int TW = LANES * TW_W;

  state_t            state, state_n;
  logic [ADDR_W-1:0] k, k_step, half, stride_q;
  logic [SH_W-1:0]   sh;
  logic              bank_q;
  logic              issue, last, start, advance;

  assign half    = ADDR_W'(fft_n(i_point_configuration) >> 1);
  assign k_step  = k + ADDR_W'(LANES);
  assign issue   = (state == S_RUN) && i_working;
  assign last    = issue && (k_step >= half);
  assign start   = (state == S_IDLE) && i_working && !i_fft_done;
  assign advance = (state == S_WAIT) && i_new_stage_trigger
                   && !i_fft_done;

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (i_working) state_n = S_RUN;
      S_RUN:   if (last) state_n = S_WAIT;
      S_WAIT:  if (i_new_stage_trigger) state_n = S_RUN;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (i_fft_done) state_n = S_DONE;
  end

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      k        <= '0;
      sh       <= '0;
      stride_q <= '0;
      bank_q   <= 1'b0;
    end else if (start) begin
      k        <= '0;
      sh       <= '0;
      stride_q <= i_stride;
      bank_q   <= i_sram_read_register;
    end else if (advance) begin
      k        <= '0;
      sh       <= sh + SH_W'(1);
      stride_q <= i_stride;
      bank_q   <= i_sram_read_register;
    end else if (issue) begin
      // saturate at N/2 so a partial last group never wraps
      k <= last ? half : k_step;
    end
  end

  logic [LW-1:0] c_top, c_bot;
  logic [TW-1:0] c_tw;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ADDR_W-1:0] b, top, bot;
    logic [TW_W-1:0]   tw;
    logic              en;

    assign b  = k + ADDR_W'(l);
    assign en = issue && (b < half);

    bf_addr_calc u_calc (
      .b       (b),
      .stride  (stride_q),
      .sh      (sh),
      .top     (top),
      .bot     (bot),
      .twiddle (tw)
    );

    assign c_top[l*ADDR_W +: ADDR_W] = en ? top : '0;
    assign c_bot[l*ADDR_W +: ADDR_W] = en ? bot : '0;
    assign c_tw[l*TW_W +: TW_W]      = en ? tw  : '0;
  end

  logic [PIPE-1:0] p_valid, p_last, p_bank;
  logic [LW-1:0]   p_top [PIPE];
  logic [LW-1:0]   p_bot [PIPE];
  logic [TW-1:0]   p_tw  [PIPE];

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      p_valid <= '0;
      p_last  <= '0;
      p_bank  <= '0;
      for (int i = 0; i < PIPE; i++) begin
        p_top[i] <= '0;
        p_bot[i] <= '0;
        p_tw[i]  <= '0;
      end
    end else begin
      p_valid[0] <= issue;
      p_last[0]  <= last;
      p_bank[0]  <= issue ? bank_q : 1'b0;
      p_top[0]   <= c_top;
      p_bot[0]   <= c_bot;
      p_tw[0]    <= c_tw;
      for (int i = 1; i < PIPE; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_last[i]  <= p_last[i-1];
        p_bank[i]  <= p_bank[i-1];
        p_top[i]   <= p_top[i-1];
        p_bot[i]   <= p_bot[i-1];
        p_tw[i]    <= p_tw[i-1];
      end
    end
  end

  assign o_valid        = p_valid[PIPE-1];
  assign o_stage_issued = p_last[PIPE-1];
  assign o_bank_sel     = p_bank[PIPE-1];
  assign o_addr_top     = p_top[PIPE-1];
  assign o_addr_bot     = p_bot[PIPE-1];
  assign o_twiddle_idx  = p_tw[PIPE-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: scoreboard bench for fft_addr_gen; expected butterfly
// groups are queued per stage from a div/mod model and popped on o_valid.
module tb_fft_addr_gen;

  localparam int LANES = 4;
  localparam int PIPE  = 2;
  localparam int AW    = 10;
  localparam int TWW   = 9;

  logic                clk;
  logic                i_resetn;
  logic [2:0]          i_point_configuration;
  logic                i_working;
  logic [AW-1:0]       i_stride;
  logic                i_new_stage_trigger;
  logic                i_sram_read_register;
  logic                i_fft_done;
  logic [LANES*AW-1:0] o_addr_top;
  logic [LANES*AW-1:0] o_addr_bot;
  logic [LANES*TWW-1:0] o_twiddle_idx;
  logic                o_bank_sel;
  logic                o_valid;
  logic                o_stage_issued;

  fft_addr_gen #(.LANES(LANES), .PIPE(PIPE)) dut (
    .clk                   (clk),
    .i_resetn              (i_resetn),
    .i_point_configuration (i_point_configuration),
    .i_working             (i_working),
    .i_stride              (i_stride),
    .i_new_stage_trigger   (i_new_stage_trigger),
    .i_sram_read_register  (i_sram_read_register),
    .i_fft_done            (i_fft_done),
    .o_addr_top            (o_addr_top),
    .o_addr_bot            (o_addr_bot),
    .o_twiddle_idx         (o_twiddle_idx),
    .o_bank_sel            (o_bank_sel),
    .o_valid               (o_valid),
    .o_stage_issued        (o_stage_issued)
  );

  typedef struct {
    logic [LANES*AW-1:0]  top;
    logic [LANES*AW-1:0]  bot;
    logic [LANES*TWW-1:0] tw;
    logic                 bank;
    logic                 last;
  } exp_t;

  exp_t sb[$];
  int   vec;
  int   errs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vec=%0d", vec);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_stage(int code, int s, int sh, bit bank);
    int   half;
    int   b;
    int   top;
    exp_t e;
    half = (8 << code) / 2;
    for (int g = 0; g < half; g += LANES) begin
      e.top  = '0;
      e.bot  = '0;
      e.tw   = '0;
      e.bank = bank;
      e.last = (g + LANES >= half);
      for (int l = 0; l < LANES; l++) begin
        b = g + l;
        if (b < half) begin
          top = (b / s) * 2 * s + (b % s);
          e.top[l*AW +: AW]   = AW'(top);
          e.bot[l*AW +: AW]   = AW'(top + s);
          e.tw[l*TWW +: TWW]  = TWW'((b % s) << sh);
        end
      end
      sb.push_back(e);
    end
  endfunction

  task automatic do_reset();
    i_resetn              = 1'b0;
    i_working             = 1'b0;
    i_new_stage_trigger   = 1'b0;
    i_fft_done            = 1'b0;
    i_sram_read_register  = 1'b0;
    i_stride              = '0;
    i_point_configuration = '0;
    sb.delete();
    tick();
    tick();
    i_resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int nv;
    i_resetn              = 1'b0;
    i_working             = 1'b1;
    i_stride              = 10'd4;
    i_sram_read_register  = 1'b1;
    i_point_configuration = 3'd0;
    i_new_stage_trigger   = 1'b0;
    i_fft_done            = 1'b0;
    repeat (3) tick();
    vec++;
    if ({o_valid, o_stage_issued, o_bank_sel} !== 3'b000) begin
      errs++;
      $display("FAIL reset_ctl: got %b%b%b want 000",
               o_valid, o_stage_issued, o_bank_sel);
    end
    vec++;
    if ({o_addr_top, o_addr_bot, o_twiddle_idx} !== '0) begin
      errs++;
      $display("FAIL reset_data: top=%h bot=%h tw=%h want 0",
               o_addr_top, o_addr_bot, o_twiddle_idx);
    end
    i_working = 1'b0;
    tick();
    i_resetn = 1'b1;
    tick();
    i_new_stage_trigger = 1'b1;
    tick();
    i_new_stage_trigger = 1'b0;
    nv = 0;
    repeat (5) begin
      tick();
      if (o_valid) nv++;
    end
    vec++;
    if (nv != 0) begin
      errs++;
      $display("FAIL idle_trigger: got %0d valids want 0", nv);
    end
  endtask

  task automatic test_first_stage();
    int   first;
    int   pulses;
    exp_t e;
    do_reset();
    i_point_configuration = 3'd0;
    i_stride              = 10'd4;
    i_sram_read_register  = 1'b0;
    push_stage(0, 4, 0, 1'b0);
    i_working = 1'b1;
    first  = 0;
    pulses = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (o_stage_issued) pulses++;
      if (o_valid && first == 0) first = t;
      vec++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL first_stage extra: top=%h", o_addr_top);
        end else begin
          e = sb.pop_front();
          if ({o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
               o_stage_issued} !== {e.top, e.bot, e.tw, e.bank, e.last}) begin
            errs++;
            $display("FAIL first_stage data: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                     o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
                     o_stage_issued, e.top, e.bot, e.tw, e.bank, e.last);
          end
        end
      end else if (o_stage_issued !== 1'b0) begin
        errs++;
        $display("FAIL first_stage issued: got 1 without valid want 0");
      end
    end
    vec++;
    if (first != PIPE + 1) begin
      errs++;
      $display("FAIL first_stage latency: got %0d want %0d", first, PIPE + 1);
    end
    vec++;
    if (pulses != 1 || sb.size() != 0) begin
      errs++;
      $display("FAIL first_stage end: pulses=%0d left=%0d want 1/0",
               pulses, sb.size());
    end
  endtask

  task automatic test_next_stage();
    int   first;
    int   pulses;
    exp_t e;
    i_stride             = 10'd2;
    i_sram_read_register = 1'b1;
    push_stage(0, 2, 1, 1'b1);
    i_new_stage_trigger = 1'b1;
    first  = 0;
    pulses = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      i_new_stage_trigger = 1'b0;
      if (o_stage_issued) pulses++;
      if (o_valid && first == 0) first = t;
      vec++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL next_stage extra: top=%h", o_addr_top);
        end else begin
          e = sb.pop_front();
          if ({o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
               o_stage_issued} !== {e.top, e.bot, e.tw, e.bank, e.last}) begin
            errs++;
            $display("FAIL next_stage data: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                     o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
                     o_stage_issued, e.top, e.bot, e.tw, e.bank, e.last);
          end
        end
      end else if (o_stage_issued !== 1'b0) begin
        errs++;
        $display("FAIL next_stage issued: got 1 without valid want 0");
      end
    end
    vec++;
    if (first != PIPE + 1) begin
      errs++;
      $display("FAIL next_stage latency: got %0d want %0d", first, PIPE + 1);
    end
    vec++;
    if (pulses != 1 || sb.size() != 0) begin
      errs++;
      $display("FAIL next_stage end: pulses=%0d left=%0d want 1/0",
               pulses, sb.size());
    end
  endtask

  task automatic test_long_stage();
    int   nv;
    int   pulses;
    exp_t e;
    do_reset();
    i_point_configuration = 3'd7;
    i_stride              = 10'd512;
    i_sram_read_register  = 1'b0;
    push_stage(7, 512, 0, 1'b0);
    i_working = 1'b1;
    nv     = 0;
    pulses = 0;
    for (int t = 1; t <= 140; t++) begin
      tick();
      i_new_stage_trigger = (t == 20);
      if (o_stage_issued) pulses++;
      vec++;
      if (o_valid) begin
        nv++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL long_stage extra: top=%h", o_addr_top);
        end else begin
          e = sb.pop_front();
          if ({o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
               o_stage_issued} !== {e.top, e.bot, e.tw, e.bank, e.last}) begin
            errs++;
            $display("FAIL long_stage data: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                     o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
                     o_stage_issued, e.top, e.bot, e.tw, e.bank, e.last);
          end
        end
      end else if (o_stage_issued !== 1'b0) begin
        errs++;
        $display("FAIL long_stage issued: got 1 without valid want 0");
      end
    end
    vec++;
    if (nv != 128) begin
      errs++;
      $display("FAIL long_stage count: got %0d want 128", nv);
    end
    vec++;
    if (pulses != 1 || sb.size() != 0) begin
      errs++;
      $display("FAIL long_stage end: pulses=%0d left=%0d want 1/0",
               pulses, sb.size());
    end
  endtask

  task automatic test_working_gap();
    int   nv;
    int   gap;
    int   maxgap;
    bit   seen;
    exp_t e;
    do_reset();
    i_point_configuration = 3'd3;
    i_stride              = 10'd32;
    push_stage(3, 32, 0, 1'b0);
    i_working = 1'b1;
    nv     = 0;
    gap    = 0;
    maxgap = 0;
    seen   = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      i_working = !(t >= 4 && t < 7);
      vec++;
      if (o_valid) begin
        nv++;
        if (seen && gap > maxgap) maxgap = gap;
        gap  = 0;
        seen = 1'b1;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL working_gap extra: top=%h", o_addr_top);
        end else begin
          e = sb.pop_front();
          if ({o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
               o_stage_issued} !== {e.top, e.bot, e.tw, e.bank, e.last}) begin
            errs++;
            $display("FAIL working_gap data: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                     o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
                     o_stage_issued, e.top, e.bot, e.tw, e.bank, e.last);
          end
        end
      end else begin
        if (seen) gap++;
        if (o_stage_issued !== 1'b0) begin
          errs++;
          $display("FAIL working_gap issued: got 1 without valid want 0");
        end
      end
    end
    vec++;
    if (maxgap != 3) begin
      errs++;
      $display("FAIL working_gap gap: got %0d want 3", maxgap);
    end
    vec++;
    if (nv != 8 || sb.size() != 0) begin
      errs++;
      $display("FAIL working_gap count: got %0d left=%0d want 8/0",
               nv, sb.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int   first;
    exp_t e;
    do_reset();
    i_point_configuration = 3'd7;
    i_stride              = 10'd512;
    push_stage(7, 512, 0, 1'b0);
    i_working = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      vec++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL mid_run extra: top=%h", o_addr_top);
        end else begin
          e = sb.pop_front();
          if ({o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
               o_stage_issued} !== {e.top, e.bot, e.tw, e.bank, e.last}) begin
            errs++;
            $display("FAIL mid_run data: got %h/%h/%h want %h/%h/%h",
                     o_addr_top, o_addr_bot, o_twiddle_idx,
                     e.top, e.bot, e.tw);
          end
        end
      end
    end
    i_resetn = 1'b0;
    #1;
    vec++;
    if ({o_valid, o_addr_top} !== '0) begin
      errs++;
      $display("FAIL mid_run reset: valid=%b top=%h want 0", o_valid,
               o_addr_top);
    end
    sb.delete();
    tick();
    i_resetn = 1'b1;
    push_stage(7, 512, 0, 1'b0);
    first = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (o_valid && first == 0) begin
        first = t;
        e = sb.pop_front();
        vec++;
        if (o_addr_top !== e.top) begin
          errs++;
          $display("FAIL restart_top: got %h want %h", o_addr_top, e.top);
        end
      end
    end
    vec++;
    if (first != PIPE + 1) begin
      errs++;
      $display("FAIL restart_latency: got %0d want %0d", first, PIPE + 1);
    end
  endtask

  task automatic test_done_with_trigger();
    int   nv;
    int   pulses;
    exp_t e;
    do_reset();
    i_point_configuration = 3'd1;
    i_stride              = 10'd8;
    push_stage(1, 8, 0, 1'b0);
    i_working = 1'b1;
    nv     = 0;
    pulses = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      i_new_stage_trigger = (t == 3 || t == 10);
      i_fft_done          = (t == 3);
      if (o_stage_issued) pulses++;
      vec++;
      if (o_valid) begin
        nv++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL done extra: t=%0d top=%h", t, o_addr_top);
        end else begin
          e = sb.pop_front();
          if ({o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
               o_stage_issued} !== {e.top, e.bot, e.tw, e.bank, e.last}) begin
            errs++;
            $display("FAIL done data: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                     o_addr_top, o_addr_bot, o_twiddle_idx, o_bank_sel,
                     o_stage_issued, e.top, e.bot, e.tw, e.bank, e.last);
          end
        end
      end else if (o_stage_issued !== 1'b0) begin
        errs++;
        $display("FAIL done issued: got 1 without valid want 0");
      end
    end
    vec++;
    if (nv != 2 || pulses != 1 || sb.size() != 0) begin
      errs++;
      $display("FAIL done drain: valids=%0d pulses=%0d left=%0d want 2/1/0",
               nv, pulses, sb.size());
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_first_stage();
    test_next_stage();
    test_long_stage();
    test_working_gap();
    test_reset_mid_run();
    test_done_with_trigger();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning butterflies issued per cycle (power of two, 1..4).
REQ-002 SHALL have parameter PIPE, default 2, meaning address pipeline depth in cycles (≥1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is rising-edge.
REQ-004 SHALL have port i_resetn  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port i_point_configuration  input  3  meaning FFT size code; N = 8 << code.
REQ-006 SHALL have port i_working  input  1  meaning the FFT is enabled; issue stalls while low.
REQ-007 SHALL have port i_stride  input  10  meaning current-stage stride S from point configuration.
REQ-008 SHALL have port i_new_stage_trigger  input  1  meaning a single-cycle pulse: previous stage written back, next stage may start.
REQ-009 SHALL have port i_sram_read_register  input  1  meaning the ping-pong bank to read this stage.
REQ-010 SHALL have port i_fft_done  input  1  meaning the transform is complete.
REQ-011 SHALL have port o_addr_top  output  LANES*10  meaning top-operand read address per lane.
REQ-012 SHALL have port o_addr_bot  output  LANES*10  meaning bottom-operand read address per lane.
REQ-013 SHALL have port o_twiddle_idx  output  LANES*9  meaning twiddle ROM index per lane.
REQ-014 SHALL have port o_bank_sel  output  1  meaning the read bank associated with the outputs.
REQ-015 SHALL have port o_valid  output  1  meaning the outputs on this cycle are a valid butterfly issue.
REQ-016 SHALL have port o_stage_issued  output  1  meaning all butterflies of the current stage have left the pipeline.

Function
REQ-017 SHALL run FSM IDLE→RUN on the first cycle i_working=1, RUN→WAIT when butterfly counter k reaches N/2, WAIT→RUN on i_new_stage_trigger, and any state→DONE on i_fft_done.
REQ-018 SHALL leave DONE only through reset.
REQ-019 SHALL, in RUN with i_working=1, issue lane l butterfly b=k+l and then set k to k+LANES; with i_working=0 it SHALL hold k and issue nothing.
REQ-020 SHALL compute j=b mod S, g=b/S, top=g*2S+j, bot=top+S, using shifts and masks only, since S is a power of two.
REQ-021 SHALL compute twiddle=j<<sh, where sh=log2(N/2)-log2(S); sh SHALL be 0 on IDLE→RUN and SHALL increment on every WAIT→RUN.
REQ-022 SHALL sample i_stride and i_sram_read_register on IDLE→RUN and on each trigger, and hold them constant for the stage.
REQ-023 SHALL present outputs exactly PIPE cycles after issue, with o_valid and o_bank_sel delayed identically.
REQ-024 SHALL clear k to 0 on the trigger cycle, so the next stage's first issue occurs the cycle after the trigger.
REQ-025 SHALL ignore i_new_stage_trigger in IDLE and RUN.
REQ-026 SHALL, when N/2 < LANES, mask the excess lanes with o_valid and SHALL NOT let k wrap past N/2.
REQ-027 SHALL pulse o_stage_issued for one cycle when the last valid issue of a stage leaves the pipeline.
REQ-028 SHALL, if i_fft_done and a trigger coincide, give DONE priority, and in DONE SHALL still drain the in-flight pipeline.

Reset
REQ-029 SHALL force, while i_resetn=0, FSM=IDLE, k=0, sh=0, and all pipeline registers to 0, giving o_valid=0, o_stage_issued=0, o_bank_sel=0 and all addresses and twiddles 0.
REQ-030 SHALL abort mid-stage on reset, with no further o_valid until the next IDLE→RUN.

Structure
REQ-031 SHALL place the FSM state enum, ADDR_W=10, TW_W=9, and the N-from-code function in shared package fft_pkg.
REQ-032 SHALL contain one sub-module, bf_addr_calc, which is combinational (b, S, sh → top, bot, twiddle) and instantiated LANES times.

Verification
REQ-033 SHALL cover: code=0 (N=8), S=4, working held high → cycle PIPE gives o_valid=1, top={0,1,2,3}, bot={4,5,6,7}, tw={0,1,2,3}.
REQ-034 SHALL cover: code=0, after a trigger with S=2 → top={0,1,4,5}, bot={2,3,6,7}, tw={0,2,0,2}, and o_bank_sel toggles with i_sram_read_register.
REQ-035 SHALL cover: code=7 (N=1024), S=512 → 128 issue cycles, last issue top={508..511}, bot={1020..1023}, then o_stage_issued pulses once.
REQ-036 SHALL cover: i_working dropped for 3 cycles mid-stage → no o_valid gap beyond 3 cycles, and no duplicated or skipped b.
REQ-037 SHALL cover: reset asserted mid-RUN at k=64 → o_valid=0 immediately, and restart at top={0,1,2,3}.
REQ-038 SHALL cover: i_fft_done together with a trigger → state DONE, in-flight valids drain, then no further o_valid.
